// File: rtl/spm_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : spm_burst_bridge
// Description : Terminates a fixed-length OCP burst port and sequences each
//               beat into single-word accesses on a byte-enabled scratchpad.
//               Read data and write completion are returned as registered
//               OCP responses.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_burst_bridge #(
  parameter int BURST_LEN  = 4,
  parameter int SPM_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  // OCP burst slave port
  input  logic [2:0]            io_M_Cmd,
  input  logic [31:0]           io_M_Addr,
  input  logic [31:0]           io_M_Data,
  input  logic [3:0]            io_M_DataByteEn,
  input  logic                  io_M_DataValid,
  output logic                  io_S_CmdAccept,
  output logic                  io_S_DataAccept,
  output logic [1:0]            io_S_Resp,
  output logic [31:0]           io_S_Data,
  // Scratchpad master port
  output logic [31:0]           io_spm_M_Data,
  output logic [SPM_ADDR_W-1:0] io_spm_M_Addr,
  output logic [3:0]            io_spm_M_ByteEn,
  output logic                  io_spm_M_We,
  input  logic [31:0]           io_spm_S_Data
);

  localparam int CNT_W = $clog2(BURST_LEN);

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_BURST = 2'd1,
    S_WR_DATA  = 2'd2,
    S_WR_RESP  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SPM_ADDR_W-1:0]   base_q;
  logic [1:0]              resp_q;
  logic [31:0]             rdata_q;

  // Burst-aligned word address of the incoming command; the byte offset and
  // the in-burst word bits are dropped, upper address bits alias.
  logic [SPM_ADDR_W-1:0]   cmd_base;
  logic [SPM_ADDR_W-1:0]   burst_addr;
  logic                    unused_addr_bits;

  assign cmd_base   = {io_M_Addr[SPM_ADDR_W+1:CNT_W+2], {CNT_W{1'b0}}};
  assign burst_addr = base_q + SPM_ADDR_W'(cnt_q);
  assign unused_addr_bits = ^{io_M_Addr[31:SPM_ADDR_W+2], io_M_Addr[CNT_W+1:0]};

  // Combinational handshake and scratchpad drive; writes are suppressed while
  // reset is held so an abandoned burst cannot touch memory.
  always_comb begin
    io_S_CmdAccept  = 1'b0;
    io_S_DataAccept = 1'b0;
    io_spm_M_We     = 1'b0;
    io_spm_M_ByteEn = 4'b0000;
    io_spm_M_Addr   = burst_addr;
    io_spm_M_Data   = io_M_Data;
    case (state_q)
      S_IDLE: begin
        io_S_CmdAccept = 1'b1;
        if (io_M_Cmd == CMD_WR) begin
          io_spm_M_Addr = cmd_base;
          if (io_M_DataValid) begin
            io_S_DataAccept = 1'b1;
            io_spm_M_We     = 1'b1;
            io_spm_M_ByteEn = io_M_DataByteEn;
          end
        end
      end
      S_WR_DATA: begin
        io_S_DataAccept = 1'b1;
        if (io_M_DataValid) begin
          io_spm_M_We     = 1'b1;
          io_spm_M_ByteEn = io_M_DataByteEn;
        end
      end
      default: ;
    endcase
    if (!reset) begin
      io_S_DataAccept = 1'b0;
      io_spm_M_We     = 1'b0;
      io_spm_M_ByteEn = 4'b0000;
    end
  end

  // Burst sequencer with registered OCP response and read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      resp_q  <= RESP_NULL;
      rdata_q <= '0;
    end else begin
      resp_q  <= RESP_NULL;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          case (io_M_Cmd)
            CMD_IDLE: ;
            CMD_RD: begin
              base_q  <= cmd_base;
              cnt_q   <= '0;
              state_q <= S_RD_BURST;
            end
            CMD_WR: begin
              base_q  <= cmd_base;
              cnt_q   <= io_M_DataValid ? CNT_ONE : '0;
              state_q <= S_WR_DATA;
            end
            default: resp_q <= RESP_ERR;
          endcase
        end
        S_RD_BURST: begin
          resp_q  <= RESP_DVA;
          rdata_q <= io_spm_S_Data;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_WR_DATA: begin
          if (io_M_DataValid) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              resp_q  <= RESP_DVA;
              state_q <= S_WR_RESP;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        S_WR_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io_S_Resp = resp_q;
  assign io_S_Data = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spm_burst_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_burst_bridge
// Description : Directed self-checking bench for spm_burst_bridge with a
//               behavioural byte-enabled scratchpad attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_burst_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        valid;
  logic        cmd_acc;
  logic        data_acc;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic [31:0] spm_wdata;
  logic [7:0]  spm_addr;
  logic [3:0]  spm_be;
  logic        spm_we;
  logic [31:0] spm_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  logic        preload;
  logic [31:0] wbeat [4];
  logic [3:0]  wbe   [4];

  always #5 clk = ~clk;

  spm_burst_bridge dut (
    .clk             (clk),
    .reset           (reset),
    .io_M_Cmd        (cmd),
    .io_M_Addr       (addr),
    .io_M_Data       (wdata),
    .io_M_DataByteEn (be),
    .io_M_DataValid  (valid),
    .io_S_CmdAccept  (cmd_acc),
    .io_S_DataAccept (data_acc),
    .io_S_Resp       (resp),
    .io_S_Data       (rdata),
    .io_spm_M_Data   (spm_wdata),
    .io_spm_M_Addr   (spm_addr),
    .io_spm_M_ByteEn (spm_be),
    .io_spm_M_We     (spm_we),
    .io_spm_S_Data   (spm_rdata)
  );

  // Scratchpad: byte-enabled synchronous write, combinational read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
    end else if (spm_we) begin
      for (int b = 0; b < 4; b++)
        if (spm_be[b]) mem[spm_addr][8*b +: 8] <= spm_wdata[8*b +: 8];
    end
  end
  assign spm_rdata = mem[spm_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cmd = 3'b000; addr = 32'h0; wdata = 32'h0; be = 4'h0; valid = 1'b0;
  endtask

  task automatic test_reset();
    preload = 1'b1;
    reset   = 1'b0;
    cmd = 3'b001; addr = 32'h40; wdata = 32'hDEADBEEF; be = 4'hF; valid = 1'b1;
    tick();
    preload = 1'b0;
    total++; if (spm_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b exp 0", spm_we); end
    total++; if (data_acc !== 1'b0) begin bad++; $display("FAIL rst_dacc: got %b exp 0", data_acc); end
    tick();
    drive_idle();
    reset = 1'b1;
    #1;
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL rst_resp: got %b exp 00", resp); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_data: got %h exp 0", rdata); end
    total++; if (spm_we !== 1'b0) begin bad++; $display("FAIL rst_we_rel: got %b exp 0", spm_we); end
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL rst_cacc: got %b exp 1", cmd_acc); end
    tick();
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL idle_resp: got %b exp 00", resp); end
  endtask

  task automatic test_write_burst();
    wbeat[0] = 32'h11111111; wbeat[1] = 32'h22222222;
    wbeat[2] = 32'h33333333; wbeat[3] = 32'h44444444;
    tick();
    cmd = 3'b001; addr = 32'h40; valid = 1'b1; be = 4'hF; wdata = wbeat[0];
    #1;
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL wr_cacc: got %b exp 1", cmd_acc); end
    total++; if (data_acc !== 1'b1) begin bad++; $display("FAIL wr_dacc0: got %b exp 1", data_acc); end
    total++; if (spm_we !== 1'b1 || spm_addr !== 8'd16) begin bad++; $display("FAIL wr_beat0: got we=%b addr=%0d exp we=1 addr=16", spm_we, spm_addr); end
    for (int i = 1; i < 4; i++) begin
      tick();
      cmd = 3'b000; wdata = wbeat[i];
      #1;
      total++; if (spm_we !== 1'b1 || spm_addr !== 8'(16 + i)) begin bad++; $display("FAIL wr_beat%0d: got we=%b addr=%0d exp we=1 addr=%0d", i, spm_we, spm_addr, 16 + i); end
    end
    tick();
    drive_idle();
    #1;
    total++; if (resp !== 2'b01) begin bad++; $display("FAIL wr_dva: got %b exp 01", resp); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL wr_dva_data: got %h exp 0", rdata); end
    total++; if (spm_we !== 1'b0) begin bad++; $display("FAIL wr_resp_we: got %b exp 0", spm_we); end
    tick();
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL wr_after_resp: got %b exp 00", resp); end
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL wr_idle_cacc: got %b exp 1", cmd_acc); end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[16 + i] !== wbeat[i]) begin bad++; $display("FAIL wr_mem%0d: got %h exp %h", i, mem[16 + i], wbeat[i]); end
    end
  endtask

  task automatic test_read_burst();
    tick();
    cmd = 3'b010; addr = 32'h40;
    #1;
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL rd_cacc: got %b exp 1", cmd_acc); end
    tick();
    cmd = 3'b000;
    #1;
    total++; if (cmd_acc !== 1'b0) begin bad++; $display("FAIL rd_busy_cacc: got %b exp 0", cmd_acc); end
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL rd_t1_resp: got %b exp 00", resp); end
    total++; if (spm_we !== 1'b0 || spm_addr !== 8'd16) begin bad++; $display("FAIL rd_t1_spm: got we=%b addr=%0d exp we=0 addr=16", spm_we, spm_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (resp !== 2'b01 || rdata !== wbeat[i]) begin bad++; $display("FAIL rd_word%0d: got resp=%b data=%h exp resp=01 data=%h", i, resp, rdata, wbeat[i]); end
    end
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL rd_last_cacc: got %b exp 1", cmd_acc); end
    tick();
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL rd_after: got %b exp 00", resp); end
  endtask

  task automatic test_stall_byteen();
    wbeat[0] = 32'h5A5A5A5A; wbe[0] = 4'hF;
    wbeat[1] = 32'h6B6B6B6B; wbe[1] = 4'hF;
    wbeat[2] = 32'hAABBCCDD; wbe[2] = 4'b0101;
    wbeat[3] = 32'h7C7C7C7C; wbe[3] = 4'hF;
    tick();
    cmd = 3'b001; addr = 32'h44; valid = 1'b1; wdata = wbeat[0]; be = wbe[0];
    #1;
    total++; if (spm_we !== 1'b1 || spm_addr !== 8'd16) begin bad++; $display("FAIL st_beat0: got we=%b addr=%0d exp we=1 addr=16", spm_we, spm_addr); end
    for (int i = 1; i < 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        tick();
        cmd = 3'b000; valid = 1'b0; wdata = 32'hFFFFFFFF; be = 4'hF;
        #1;
        total++; if (spm_we !== 1'b0 || data_acc !== 1'b1 || resp !== 2'b00) begin bad++; $display("FAIL st_gap%0d_%0d: got we=%b dacc=%b resp=%b exp we=0 dacc=1 resp=00", i, g, spm_we, data_acc, resp); end
      end
      tick();
      valid = 1'b1; wdata = wbeat[i]; be = wbe[i];
      #1;
      total++; if (spm_we !== 1'b1 || spm_addr !== 8'(16 + i) || spm_be !== wbe[i]) begin bad++; $display("FAIL st_beat%0d: got we=%b addr=%0d be=%b exp we=1 addr=%0d be=%b", i, spm_we, spm_addr, spm_be, 16 + i, wbe[i]); end
    end
    tick();
    drive_idle();
    #1;
    total++; if (resp !== 2'b01) begin bad++; $display("FAIL st_dva: got %b exp 01", resp); end
    tick();
    total++; if (mem[16] !== 32'h5A5A5A5A) begin bad++; $display("FAIL st_mem16: got %h exp 5a5a5a5a", mem[16]); end
    total++; if (mem[17] !== 32'h6B6B6B6B) begin bad++; $display("FAIL st_mem17: got %h exp 6b6b6b6b", mem[17]); end
    total++; if (mem[18] !== 32'h33BB33DD) begin bad++; $display("FAIL st_mem18: got %h exp 33bb33dd", mem[18]); end
    total++; if (mem[19] !== 32'h7C7C7C7C) begin bad++; $display("FAIL st_mem19: got %h exp 7c7c7c7c", mem[19]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    tick();
    cmd = 3'b010; addr = 32'h3F0;
    #1;
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL b2b_cacc0: got %b exp 1", cmd_acc); end
    tick();
    cmd = 3'b000;
    #1;
    total++; if (spm_addr !== 8'd252) begin bad++; $display("FAIL b2b_addr0: got %0d exp 252", spm_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin cmd = 3'b010; addr = 32'h400; end
      #1;
      exp_w = 32'hC0DE00FC + 32'(i);
      total++; if (resp !== 2'b01 || rdata !== exp_w) begin bad++; $display("FAIL b2b_a%0d: got resp=%b data=%h exp resp=01 data=%h", i, resp, rdata, exp_w); end
    end
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL b2b_cacc1: got %b exp 1", cmd_acc); end
    tick();
    cmd = 3'b000;
    #1;
    total++; if (spm_addr !== 8'd0) begin bad++; $display("FAIL b2b_addr1: got %0d exp 0", spm_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_w = 32'hC0DE0000 + 32'(i);
      total++; if (resp !== 2'b01 || rdata !== exp_w) begin bad++; $display("FAIL b2b_b%0d: got resp=%b data=%h exp resp=01 data=%h", i, resp, rdata, exp_w); end
    end
    tick();
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL b2b_after: got %b exp 00", resp); end
  endtask

  task automatic test_illegal();
    logic [31:0] exp_w;
    tick();
    cmd = 3'b100; addr = 32'h0; valid = 1'b1; wdata = 32'hFFFFFFFF; be = 4'hF;
    #1;
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL ill_cacc: got %b exp 1", cmd_acc); end
    total++; if (spm_we !== 1'b0) begin bad++; $display("FAIL ill_we: got %b exp 0", spm_we); end
    tick();
    cmd = 3'b010; addr = 32'h400; valid = 1'b0; wdata = 32'h0; be = 4'h0;
    #1;
    total++; if (resp !== 2'b11) begin bad++; $display("FAIL ill_err: got %b exp 11", resp); end
    total++; if (cmd_acc !== 1'b1) begin bad++; $display("FAIL ill_next_cacc: got %b exp 1", cmd_acc); end
    tick();
    cmd = 3'b000;
    #1;
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL ill_err_once: got %b exp 00", resp); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_w = 32'hC0DE0000 + 32'(i);
      total++; if (resp !== 2'b01 || rdata !== exp_w) begin bad++; $display("FAIL ill_rd%0d: got resp=%b data=%h exp resp=01 data=%h", i, resp, rdata, exp_w); end
    end
  endtask

  task automatic test_reset_mid_write();
    tick();
    cmd = 3'b001; addr = 32'h80; valid = 1'b1; be = 4'hF; wdata = 32'hD0000000;
    tick();
    cmd = 3'b000; wdata = 32'hD1111111;
    tick();
    reset = 1'b0; wdata = 32'hD2222222;
    #1;
    total++; if (spm_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %b exp 0", spm_we); end
    tick();
    reset = 1'b1;
    drive_idle();
    #1;
    total++; if (resp !== 2'b00 || cmd_acc !== 1'b1 || spm_we !== 1'b0) begin bad++; $display("FAIL mid_rst_idle: got resp=%b cacc=%b we=%b exp resp=00 cacc=1 we=0", resp, cmd_acc, spm_we); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (resp !== 2'b00) begin bad++; $display("FAIL mid_rst_noresp%0d: got %b exp 00", i, resp); end
    end
    total++; if (mem[32] !== 32'hD0000000) begin bad++; $display("FAIL mid_mem32: got %h exp d0000000", mem[32]); end
    total++; if (mem[33] !== 32'hD1111111) begin bad++; $display("FAIL mid_mem33: got %h exp d1111111", mem[33]); end
    total++; if (mem[34] !== 32'hC0DE0022) begin bad++; $display("FAIL mid_mem34: got %h exp c0de0022", mem[34]); end
    total++; if (mem[35] !== 32'hC0DE0023) begin bad++; $display("FAIL mid_mem35: got %h exp c0de0023", mem[35]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    preload = 1'b1;
    reset   = 1'b0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_stall_byteen();
    test_back_to_back();
    test_illegal();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
